// File: rtl/sram_pkg.sv
// Shared types and helpers for the 1W1R SRAM family: FSM state encoding,
// read-under-write mode codes and the write-mask lane merge.
package sram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_CLEAR
    } sram_state_e;

    localparam int RUW_OLD = 0;
    localparam int RUW_NEW = 1;

    // Widest word / most lanes merge_lanes handles; callers zero-extend and truncate.
    localparam int MERGE_MAX_W     = 128;
    localparam int MERGE_MAX_LANES = 16;

    function automatic logic [MERGE_MAX_W-1:0] merge_lanes(
        input logic [MERGE_MAX_W-1:0]     old_word,
        input logic [MERGE_MAX_W-1:0]     new_word,
        input logic [MERGE_MAX_LANES-1:0] mask,
        input int                         lane_w
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int l = 0; l < MERGE_MAX_LANES; l++) begin
            if (mask[l]) begin
                for (int b = 0; b < MERGE_MAX_W; b++) begin
                    if (b >= l * lane_w && b < (l + 1) * lane_w) res[b] = new_word[b];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_1w1r_clr_if.sv
// Request/response bundle of the 1W1R SRAM: write port, read port and clear control.
interface sram_1w1r_clr_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int MASK_W = 4
) ();
    logic              wr_en;
    logic [MASK_W-1:0] wr_mask;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              clr_req;
    logic              busy;

    modport master (
        output wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr, clr_req,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_mask, wr_addr, wr_data, rd_en, rd_addr, clr_req,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/sram_rd_pipe.sv
// Read data/valid pipeline of depth 1 or 2; the output register holds the last
// result until the next valid read arrives.
module sram_rd_pipe #(
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              in_vld,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data
);
    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sram_rd_pipe: RD_LATENCY must be 1 or 2");
    end

    if (RD_LATENCY == 2) begin : g_lat2
        // Stage p0: extra register; valid is flushed by reset, data is not
        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) vld_p0 <= 1'b0;
            else          vld_p0 <= in_vld;
        end
        always_ff @(posedge aclk) begin
            if (in_vld) data_p0 <= in_data;
        end
    end else begin : g_lat1
        assign vld_p0  = in_vld;
        assign data_p0 = in_data;
    end

    // Stage p1: output register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) data_p1 <= data_p0;
        end
    end

    assign out_vld  = vld_p1;
    assign out_data = data_p1;
endmodule

// File: rtl/sram_1w1r_clr.sv
// Simple-dual-port SRAM with lane write mask, read-under-write forwarding,
// 1/2-cycle read latency and a clear sweep that zeroes the array.
module sram_1w1r_clr
    import sram_pkg::*;
#(
    parameter int WORD_COUNT   = 512,
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int MASK_W       = 4,
    parameter int RD_LATENCY   = 1,
    parameter int RUW_MODE     = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input logic           aclk,
    input logic           aresetn,
    sram_1w1r_clr_if.slave bus
);
    localparam int                LW        = DATA_W / MASK_W;
    localparam logic [ADDR_W:0]   WC_EXT    = (ADDR_W + 1)'(WORD_COUNT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);

    if (ADDR_W < $clog2(WORD_COUNT) || DATA_W % MASK_W != 0 ||
        DATA_W > MERGE_MAX_W || MASK_W > MERGE_MAX_LANES ||
        (RUW_MODE != RUW_OLD && RUW_MODE != RUW_NEW)) begin : g_bad_params
        $error("sram_1w1r_clr: illegal parameter combination");
    end

    logic [DATA_W-1:0] mem [WORD_COUNT];

    sram_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt;
    logic              busy;
    logic              svc_ok, wr_acc, rd_acc;
    logic              wr_in_rng, rd_in_rng;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_mask;
    logic [DATA_W-1:0] rd_word;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (bus.clr_req) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == LAST_ADDR) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CLEAR);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                 clr_cnt <= '0;
        else if (state_q != ST_CLEAR)                 clr_cnt <= '0;
        else if (clr_cnt == LAST_ADDR)                clr_cnt <= '0;
        else                                          clr_cnt <= clr_cnt + 1'b1;
    end

    // The cycle that accepts clr_req services neither port.
    assign svc_ok    = (state_q == ST_IDLE) && !bus.clr_req;
    assign wr_in_rng = {1'b0, bus.wr_addr} < WC_EXT;
    assign rd_in_rng = {1'b0, bus.rd_addr} < WC_EXT;
    assign wr_acc    = bus.wr_en && svc_ok && wr_in_rng;
    assign rd_acc    = bus.rd_en && svc_ok;

    always_comb begin
        mem_we    = wr_acc;
        mem_addr  = bus.wr_addr;
        mem_wdata = bus.wr_data;
        mem_mask  = bus.wr_mask;
        if (busy) begin
            mem_we    = 1'b1;
            mem_addr  = clr_cnt;
            mem_wdata = '0;
            mem_mask  = '1;
        end
    end

    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (mem_mask[i]) mem[mem_addr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
            end
        end
    end

    // Same-address write in the read cycle is folded in only in RUW_NEW mode.
    always_comb begin
        rd_word = '0;
        if (rd_in_rng) begin
            rd_word = mem[bus.rd_addr];
            if (RUW_MODE == RUW_NEW && wr_acc && bus.wr_addr == bus.rd_addr) begin
                rd_word = DATA_W'(merge_lanes(MERGE_MAX_W'(rd_word), MERGE_MAX_W'(bus.wr_data),
                                              MERGE_MAX_LANES'(bus.wr_mask), LW));
            end
        end
    end

    sram_rd_pipe #(
        .DATA_W    (DATA_W),
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_pipe (
        .aclk    (aclk),
        .aresetn (aresetn),
        .in_vld  (rd_acc),
        .in_data (rd_word),
        .out_vld (bus.rd_valid),
        .out_data(bus.rd_data)
    );

    assign bus.busy = busy;
endmodule

// File: tb/tb_sram_1w1r_clr.sv
// Directed bench: DUT A (512 words, latency 1, forwarding, clear on reset) and
// DUT B (20 words, latency 2, old-data RUW, no clear on reset).
module tb_sram_1w1r_clr;
    logic aclk = 1'b0;
    logic rst_a_n, rst_b_n;
    always #5 aclk = ~aclk;

    sram_1w1r_clr_if #(.ADDR_W(9), .DATA_W(32), .MASK_W(4)) a_if ();
    sram_1w1r_clr_if #(.ADDR_W(5), .DATA_W(32), .MASK_W(4)) b_if ();

    sram_1w1r_clr #(
        .WORD_COUNT(512), .ADDR_W(9), .DATA_W(32), .MASK_W(4),
        .RD_LATENCY(1), .RUW_MODE(1), .CLEAR_ON_RST(1)
    ) dut_a (.aclk(aclk), .aresetn(rst_a_n), .bus(a_if));

    sram_1w1r_clr #(
        .WORD_COUNT(20), .ADDR_W(5), .DATA_W(32), .MASK_W(4),
        .RD_LATENCY(2), .RUW_MODE(0), .CLEAR_ON_RST(0)
    ) dut_b (.aclk(aclk), .aresetn(rst_b_n), .bus(b_if));

    typedef struct {
        logic        wr_en;
        logic [3:0]  wr_mask;
        logic [8:0]  wr_addr;
        logic [31:0] wr_data;
        logic        rd_en;
        logic [8:0]  rd_addr;
        logic        exp_vld;
        logic [31:0] exp_data;
    } vec_t;

    vec_t va[$];
    vec_t vb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic we, input logic [3:0] m, input logic [8:0] wa,
                                input logic [31:0] wd, input logic re, input logic [8:0] ra,
                                input logic ev, input logic [31:0] ed);
        vec_t v;
        v.wr_en = we; v.wr_mask = m; v.wr_addr = wa; v.wr_data = wd;
        v.rd_en = re; v.rd_addr = ra; v.exp_vld = ev; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic set_a(input logic we, input logic [3:0] m, input logic [8:0] wa,
                         input logic [31:0] wd, input logic re, input logic [8:0] ra,
                         input logic cr);
        a_if.wr_en = we; a_if.wr_mask = m; a_if.wr_addr = wa; a_if.wr_data = wd;
        a_if.rd_en = re; a_if.rd_addr = ra; a_if.clr_req = cr;
    endtask

    task automatic set_b(input logic we, input logic [3:0] m, input logic [8:0] wa,
                         input logic [31:0] wd, input logic re, input logic [8:0] ra,
                         input logic cr);
        b_if.wr_en = we; b_if.wr_mask = m; b_if.wr_addr = 5'(wa); b_if.wr_data = wd;
        b_if.rd_en = re; b_if.rd_addr = 5'(ra); b_if.clr_req = cr;
    endtask

    task automatic count_busy_a(output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (a_if.busy && n < 2000) begin
            tick();
            n++;
            if (a_if.rd_valid) pulses++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses, bad;

        // Single-cycle vectors for A; expected outputs are visible after the same edge.
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        1, 9'd0,   1, 32'h0));
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        1, 9'd255, 1, 32'h0));
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        1, 9'd511, 1, 32'h0));
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        0, 9'd0,   0, 32'h0));
        va.push_back(mk(1, 4'hF, 9'd5, 32'hDEADBEEF, 0, 9'd0,   0, 32'h0));
        va.push_back(mk(1, 4'h5, 9'd5, 32'h11223344, 0, 9'd0,   0, 32'h0));
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        1, 9'd5,   1, 32'hDE22BE44));
        va.push_back(mk(1, 4'hF, 9'd7, 32'hAAAAAAAA, 0, 9'd0,   0, 32'hDE22BE44));
        va.push_back(mk(1, 4'h3, 9'd7, 32'h55555555, 1, 9'd7,   1, 32'hAAAA5555));
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        1, 9'd7,   1, 32'hAAAA5555));
        va.push_back(mk(1, 4'hF, 9'd9, 32'h12345678, 1, 9'd8,   1, 32'h0));
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        1, 9'd9,   1, 32'h12345678));
        va.push_back(mk(1, 4'h0, 9'd9, 32'hFFFFFFFF, 1, 9'd9,   1, 32'h12345678));
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        1, 9'd9,   1, 32'h12345678));
        va.push_back(mk(0, 4'h0, 9'd0, 32'h0,        0, 9'd0,   0, 32'h12345678));

        // Vectors for B; read results appear one vector after the one that issued them.
        vb.push_back(mk(1, 4'hF, 9'd1,  32'h11111111, 0, 9'd0,  0, 32'h0));
        vb.push_back(mk(1, 4'hF, 9'd2,  32'h22222222, 0, 9'd0,  0, 32'h0));
        vb.push_back(mk(1, 4'hF, 9'd3,  32'h33333333, 0, 9'd0,  0, 32'h0));
        vb.push_back(mk(1, 4'hF, 9'd7,  32'hAAAAAAAA, 0, 9'd0,  0, 32'h0));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        1, 9'd1,  0, 32'h0));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        1, 9'd2,  1, 32'h11111111));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        1, 9'd3,  1, 32'h22222222));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        0, 9'd0,  1, 32'h33333333));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        0, 9'd0,  0, 32'h33333333));
        vb.push_back(mk(1, 4'h3, 9'd7,  32'h55555555, 1, 9'd7,  0, 32'h33333333));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        1, 9'd7,  1, 32'hAAAAAAAA));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        0, 9'd0,  1, 32'hAAAA5555));
        vb.push_back(mk(1, 4'hF, 9'd25, 32'hFFFFFFFF, 1, 9'd25, 0, 32'hAAAA5555));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        0, 9'd0,  1, 32'h0));
        vb.push_back(mk(1, 4'hF, 9'd19, 32'h13131313, 0, 9'd0,  0, 32'h0));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        1, 9'd19, 0, 32'h0));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        0, 9'd0,  1, 32'h13131313));
        vb.push_back(mk(0, 4'h0, 9'd0,  32'h0,        0, 9'd0,  0, 32'h13131313));

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        set_a(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 0);
        set_b(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 0);
        repeat (3) tick();

        chk("A.reset.rd_valid", 32'(a_if.rd_valid), 32'd0);
        chk("A.reset.rd_data",  a_if.rd_data, 32'h0);
        chk("A.reset.busy",     32'(a_if.busy), 32'd1);
        chk("B.reset.busy",     32'(b_if.busy), 32'd0);
        chk("B.reset.rd_valid", 32'(b_if.rd_valid), 32'd0);

        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        count_busy_a(n, pulses);
        chk("A.rst_sweep_len", 32'(n), 32'd512);
        chk("B.idle_after_rst", 32'(b_if.busy), 32'd0);

        foreach (va[i]) begin
            set_a(va[i].wr_en, va[i].wr_mask, va[i].wr_addr, va[i].wr_data,
                  va[i].rd_en, va[i].rd_addr, 1'b0);
            tick();
            chk($sformatf("A.vec%0d.rd_valid", i), 32'(a_if.rd_valid), 32'(va[i].exp_vld));
            chk($sformatf("A.vec%0d.rd_data", i), a_if.rd_data, va[i].exp_data);
        end

        // A: clear request after a read, repeated request and port traffic mid-sweep.
        set_a(0, 4'h0, 9'd0, 32'h0, 1, 9'd5, 0);
        tick();
        chk("A.preclr.rd_data", a_if.rd_data, 32'hDE22BE44);
        set_a(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 1);
        tick();
        chk("A.clr.busy", 32'(a_if.busy), 32'd1);
        n = 0;
        pulses = 0;
        while (a_if.busy && n < 2000) begin
            if (n >= 300 && n < 303) set_a(1, 4'hF, 9'd5, 32'hFFFFFFFF, 1, 9'd5, 0);
            else                     set_a(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, n == 100);
            tick();
            n++;
            if (a_if.rd_valid) pulses++;
        end
        set_a(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 0);
        chk("A.clr_sweep_len", 32'(n), 32'd512);
        chk("A.clr_rd_valid_pulses", 32'(pulses), 32'd0);
        set_a(0, 4'h0, 9'd0, 32'h0, 1, 9'd5, 0);
        tick();
        chk("A.postclr.rd_valid", 32'(a_if.rd_valid), 32'd1);
        chk("A.postclr.rd_data", a_if.rd_data, 32'h0);

        foreach (vb[i]) begin
            set_b(vb[i].wr_en, vb[i].wr_mask, vb[i].wr_addr, vb[i].wr_data,
                  vb[i].rd_en, vb[i].rd_addr, 1'b0);
            tick();
            chk($sformatf("B.vec%0d.rd_valid", i), 32'(b_if.rd_valid), 32'(vb[i].exp_vld));
            chk($sformatf("B.vec%0d.rd_data", i), b_if.rd_data, vb[i].exp_data);
        end

        // B: read in flight when clr_req is taken still completes.
        set_b(0, 4'h0, 9'd0, 32'h0, 1, 9'd1, 0);
        tick();
        chk("B.inflight.stage", 32'(b_if.rd_valid), 32'd0);
        set_b(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 1);
        tick();
        chk("B.inflight.busy", 32'(b_if.busy), 32'd1);
        chk("B.inflight.rd_valid", 32'(b_if.rd_valid), 32'd1);
        chk("B.inflight.rd_data", b_if.rd_data, 32'h11111111);
        set_b(0, 4'h0, 9'd0, 32'h0, 1, 9'd2, 0);
        tick();
        set_b(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 0);
        n = 1;
        pulses = 0;
        while (b_if.busy && n < 200) begin
            tick();
            n++;
            if (b_if.rd_valid) pulses++;
        end
        chk("B.clr_sweep_len", 32'(n), 32'd20);
        chk("B.clr_rd_valid_pulses", 32'(pulses), 32'd0);
        set_b(0, 4'h0, 9'd0, 32'h0, 1, 9'd19, 0);
        tick();
        set_b(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 0);
        tick();
        chk("B.postclr.rd_valid", 32'(b_if.rd_valid), 32'd1);
        chk("B.postclr.rd_data", b_if.rd_data, 32'h0);

        // A: reset in the middle of a sweep, then full restart.
        set_a(1, 4'hF, 9'd3,   32'h01010101, 0, 9'd0, 0); tick();
        set_a(1, 4'hF, 9'd300, 32'h03030303, 0, 9'd0, 0); tick();
        set_a(1, 4'hF, 9'd511, 32'h0F0F0F0F, 0, 9'd0, 0); tick();
        set_a(0, 4'h0, 9'd0, 32'h0, 1, 9'd300, 0);
        tick();
        chk("A.prerst.rd_data", a_if.rd_data, 32'h03030303);
        set_a(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 1);
        tick();
        set_a(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 0);
        repeat (199) tick();
        rst_a_n = 1'b0;
        #1;
        chk("A.midrst.rd_data", a_if.rd_data, 32'h0);
        chk("A.midrst.rd_valid", 32'(a_if.rd_valid), 32'd0);
        chk("A.midrst.busy", 32'(a_if.busy), 32'd1);
        tick();
        tick();
        rst_a_n = 1'b1;
        count_busy_a(n, pulses);
        chk("A.restart_sweep_len", 32'(n), 32'd512);
        bad = 0;
        for (int adr = 0; adr < 512; adr++) begin
            set_a(0, 4'h0, 9'd0, 32'h0, 1, 9'(adr), 0);
            tick();
            if (a_if.rd_valid !== 1'b1 || a_if.rd_data !== 32'h0) bad++;
        end
        set_a(0, 4'h0, 9'd0, 32'h0, 0, 9'd0, 0);
        chk("A.scan_nonzero_words", 32'(bad), 32'd0);
        tick();
        chk("A.scan_end.rd_valid", 32'(a_if.rd_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
